// File: rtl/z_store_scheduler.sv
// z_store_scheduler
//   Writes the Z result stream of the SpMM engine back into TCDM. Each Z beat
//   holds Y_BLOCK_SIZE items and becomes one TCDM store. Beats are placed
//   row-major over x_rows rows of ceil(y_columns/Y_BLOCK_SIZE) blocks. The
//   last block of a row only enables the bytes of the columns that exist.
//
// Ports
//   clk_i, rst_ni      clock, synchronous active-low reset
//   clear_i            synchronous soft clear (aborts any job, no done pulse)
//   start_i            one-cycle start pulse, only honoured while idle
//   base_address_i     Z base byte address (word aligned)
//   y_columns_i        Z columns
//   x_rows_i           Z rows
//   z_valid_i/z_ready_o/z_data_i   Z beat stream from the engine
//   tcdm_req_o/tcdm_gnt_i          store handshake towards TCDM
//   tcdm_add_o/tcdm_wen_o/tcdm_be_o/tcdm_data_o  store payload
//   busy_o             high while a job is running (incl. the done cycle)
//   done_o             one-cycle completion pulse
module z_store_scheduler #(
  parameter int unsigned Y_BLOCK_SIZE = 4,
  parameter int unsigned Z_ITEM_SIZE  = 32,
  parameter int unsigned SBW          = Y_BLOCK_SIZE * Z_ITEM_SIZE,
  parameter int unsigned CW           = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [31:0]      base_address_i,
  input  logic [CW-1:0]    y_columns_i,
  input  logic [CW-1:0]    x_rows_i,
  input  logic             z_valid_i,
  output logic             z_ready_o,
  input  logic [SBW-1:0]   z_data_i,
  output logic             tcdm_req_o,
  input  logic             tcdm_gnt_i,
  output logic [31:0]      tcdm_add_o,
  output logic             tcdm_wen_o,
  output logic [SBW/8-1:0] tcdm_be_o,
  output logic [SBW-1:0]   tcdm_data_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned IB  = Z_ITEM_SIZE / 8;
  localparam int unsigned BEW = SBW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte enables for a block with `rem` remaining columns: lanes below rem are
  // on. When rem covers the whole block every lane is on.
  function automatic logic [BEW-1:0] tail_be(input logic [CW-1:0] rem);
    logic [BEW-1:0] be;
    be = '0;
    for (int l = 0; l < int'(Y_BLOCK_SIZE); l++) begin
      if (CW'(l) < rem) be[l*IB +: IB] = '1;
    end
    return be;
  endfunction

  state_e         state_q, state_d;
  logic           buf_valid_q, buf_valid_d;
  logic           buf_last_q, buf_last_d;
  logic [31:0]    buf_add_q, buf_add_d;
  logic [BEW-1:0] buf_be_q, buf_be_d;
  logic [SBW-1:0] buf_data_q, buf_data_d;
  logic [CW-1:0]  ycols_q, ycols_d;
  logic [CW-1:0]  xrows_q, xrows_d;
  logic [31:0]    row_step_q, row_step_d;
  logic [31:0]    row_start_q, row_start_d;
  logic [31:0]    addr_q, addr_d;
  logic [CW-1:0]  col_q, col_d;
  logic [CW-1:0]  row_q, row_d;
  logic           all_acc_q, all_acc_d;

  logic           hs;
  logic           grant;
  logic           last_in_row;
  logic           final_beat;
  logic [CW-1:0]  rem;

  // col + Y_BLOCK_SIZE is evaluated one bit wider so large column counts
  // cannot wrap the comparison.
  assign last_in_row = ({1'b0, col_q} + (CW+1)'(Y_BLOCK_SIZE)) >= {1'b0, ycols_q};
  assign final_beat  = last_in_row && (row_q == (xrows_q - CW'(1)));
  assign rem         = ycols_q - col_q;

  // Ready looks at the grant combinationally so a beat can replace the buffer
  // in the same cycle the buffered store is granted.
  assign z_ready_o = (state_q == RUN) && !all_acc_q && (!buf_valid_q || tcdm_gnt_i);
  assign hs        = z_valid_i && z_ready_o;
  assign grant     = buf_valid_q && tcdm_gnt_i;

  assign tcdm_req_o  = buf_valid_q;
  assign tcdm_add_o  = buf_add_q;
  assign tcdm_be_o   = buf_be_q;
  assign tcdm_data_o = buf_data_q;
  assign tcdm_wen_o  = 1'b0;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_last_d  = buf_last_q;
    buf_add_d   = buf_add_q;
    buf_be_d    = buf_be_q;
    buf_data_d  = buf_data_q;
    ycols_d     = ycols_q;
    xrows_d     = xrows_q;
    row_step_d  = row_step_q;
    row_start_d = row_start_q;
    addr_d      = addr_q;
    col_d       = col_q;
    row_d       = row_q;
    all_acc_d   = all_acc_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          ycols_d     = y_columns_i;
          xrows_d     = x_rows_i;
          // Constant-factor scaling only; the per-row advance is an addition.
          row_step_d  = 32'(y_columns_i) * 32'(IB);
          row_start_d = base_address_i;
          addr_d      = base_address_i;
          col_d       = '0;
          row_d       = '0;
          all_acc_d   = 1'b0;
          state_d     = ((x_rows_i != '0) && (y_columns_i != '0)) ? RUN : DONE;
        end
      end
      RUN: begin
        if (hs) begin
          buf_valid_d = 1'b1;
          buf_last_d  = final_beat;
          buf_add_d   = addr_q;
          buf_be_d    = tail_be(rem);
          buf_data_d  = z_data_i;
          if (last_in_row) begin
            col_d       = '0;
            row_d       = row_q + CW'(1);
            row_start_d = row_start_q + row_step_q;
            addr_d      = row_start_q + row_step_q;
          end else begin
            col_d  = col_q + CW'(Y_BLOCK_SIZE);
            addr_d = addr_q + 32'(Y_BLOCK_SIZE * IB);
          end
          if (final_beat) all_acc_d = 1'b1;
        end else if (grant) begin
          buf_valid_d = 1'b0;
          // The final beat can only be granted without a new accept, since
          // nothing is accepted once all beats are in.
          if (buf_last_q) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clear_i) begin
      state_d     = IDLE;
      buf_valid_d = 1'b0;
      buf_last_d  = 1'b0;
      col_d       = '0;
      row_d       = '0;
      all_acc_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      buf_last_q  <= 1'b0;
      buf_add_q   <= '0;
      buf_be_q    <= '0;
      buf_data_q  <= '0;
      ycols_q     <= '0;
      xrows_q     <= '0;
      row_step_q  <= '0;
      row_start_q <= '0;
      addr_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      all_acc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_last_q  <= buf_last_d;
      buf_add_q   <= buf_add_d;
      buf_be_q    <= buf_be_d;
      buf_data_q  <= buf_data_d;
      ycols_q     <= ycols_d;
      xrows_q     <= xrows_d;
      row_step_q  <= row_step_d;
      row_start_q <= row_start_d;
      addr_q      <= addr_d;
      col_q       <= col_d;
      row_q       <= row_d;
      all_acc_q   <= all_acc_d;
    end
  end

endmodule

// File: tb/tb_z_store_scheduler.sv
module tb_z_store_scheduler;

  logic         clk;
  logic         rst_ni;
  logic         clear_i;
  logic         start_i;
  logic [31:0]  base_address_i;
  logic [15:0]  y_columns_i;
  logic [15:0]  x_rows_i;
  logic         z_valid_i;
  logic         z_ready_o;
  logic [127:0] z_data_i;
  logic         tcdm_req_o;
  logic         tcdm_gnt_i;
  logic [31:0]  tcdm_add_o;
  logic         tcdm_wen_o;
  logic [15:0]  tcdm_be_o;
  logic [127:0] tcdm_data_o;
  logic         busy_o;
  logic         done_o;

  int total = 0;
  int bad   = 0;

  z_store_scheduler dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .base_address_i (base_address_i),
    .y_columns_i    (y_columns_i),
    .x_rows_i       (x_rows_i),
    .z_valid_i      (z_valid_i),
    .z_ready_o      (z_ready_o),
    .z_data_i       (z_data_i),
    .tcdm_req_o     (tcdm_req_o),
    .tcdm_gnt_i     (tcdm_gnt_i),
    .tcdm_add_o     (tcdm_add_o),
    .tcdm_wen_o     (tcdm_wen_o),
    .tcdm_be_o      (tcdm_be_o),
    .tcdm_data_o    (tcdm_data_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One job: the expected store list is derived directly from the row-major
  // layout (address = base + r*cols*4 + c*4, tail lanes masked), then the DUT
  // is driven cycle by cycle with random valid/grant and every store checked.
  task automatic run_job(input logic [31:0] base, input int cols, input int rows,
                         input int gnt_pct, input int vld_pct, input int clear_after,
                         input bit start_mid, input bit check_tput);
    logic [127:0] beats[$];
    logic [31:0]  exp_add[$];
    logic [15:0]  exp_be[$];
    int nb, tot, acc, st, done_cnt, last_grant, first_st, last_st;
    bit hold;
    logic [31:0]  h_add;
    logic [15:0]  h_be;
    logic [127:0] h_data;

    nb  = (cols + 3) / 4;
    tot = rows * nb;
    for (int r = 0; r < rows; r++) begin
      for (int b = 0; b < nb; b++) begin
        int rem;
        rem = cols - b * 4;
        exp_add.push_back(base + 32'(r * cols * 4 + b * 16));
        exp_be.push_back(rem >= 4 ? 16'hFFFF : 16'((1 << (4 * rem)) - 1));
        beats.push_back({$urandom, $urandom, $urandom, $urandom});
      end
    end
    acc = 0; st = 0; done_cnt = 0; last_grant = -1; first_st = -1; last_st = -1;
    hold = 1'b0; h_add = '0; h_be = '0; h_data = '0;

    @(posedge clk); #1;
    start_i = 1'b1; base_address_i = base;
    y_columns_i = 16'(cols); x_rows_i = 16'(rows);
    z_valid_i = 1'b0; tcdm_gnt_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    // Inputs after the accepted start must not influence the job.
    base_address_i = $urandom; y_columns_i = 16'($urandom); x_rows_i = 16'($urandom);

    for (int cyc = 0; cyc < 400; cyc++) begin
      // Once every beat is in, valid stays high to offer beats that must not be taken.
      z_valid_i  = (acc < tot) ? ($urandom_range(99) < vld_pct) : 1'b1;
      z_data_i   = (acc < tot) ? beats[acc] : {$urandom, $urandom, $urandom, $urandom};
      tcdm_gnt_i = ($urandom_range(99) < gnt_pct);
      start_i    = start_mid && (cyc == 3);
      @(negedge clk);

      if (done_cnt == 1) begin
        chk("busy_after_done", 128'(busy_o), 128'(0));
        chk("done_single", 128'(done_o), 128'(0));
        break;
      end
      chk("busy", 128'(busy_o), 128'(1));
      chk("wen", 128'(tcdm_wen_o), 128'(0));
      if (hold) begin
        chk("hold_req", 128'(tcdm_req_o), 128'(1));
        chk("hold_add", 128'(tcdm_add_o), 128'(h_add));
        chk("hold_be", 128'(tcdm_be_o), 128'(h_be));
        chk("hold_data", tcdm_data_o, h_data);
      end
      if (acc >= tot) chk("ready_after_last", 128'(z_ready_o), 128'(0));
      if (z_valid_i && z_ready_o && acc < tot) acc++;
      if (tcdm_req_o && tcdm_gnt_i) begin
        chk("store_in_range", 128'(st < tot), 128'(1));
        if (st < tot) begin
          chk("add", 128'(tcdm_add_o), 128'(exp_add[st]));
          chk("be", 128'(tcdm_be_o), 128'(exp_be[st]));
          chk("data", tcdm_data_o, beats[st]);
        end
        if (first_st < 0) first_st = cyc;
        last_st = cyc;
        last_grant = cyc;
        st++;
      end
      hold = tcdm_req_o && !tcdm_gnt_i;
      h_add = tcdm_add_o; h_be = tcdm_be_o; h_data = tcdm_data_o;
      if (done_o) begin
        chk("done_timing", 128'(cyc), 128'(last_grant + 1));
        done_cnt++;
      end
      if (clear_after != 0 && st == clear_after) begin
        @(posedge clk); #1;
        clear_i = 1'b1; z_valid_i = 1'b0; tcdm_gnt_i = 1'b0;
        @(posedge clk); #1;
        clear_i = 1'b0;
        @(negedge clk);
        chk("clr_busy", 128'(busy_o), 128'(0));
        chk("clr_req", 128'(tcdm_req_o), 128'(0));
        chk("clr_ready", 128'(z_ready_o), 128'(0));
        for (int k = 0; k < 3; k++) begin
          chk("clr_no_done", 128'(done_o), 128'(0));
          @(negedge clk);
        end
        return;
      end
      @(posedge clk); #1;
    end

    chk("stores", 128'(st), 128'(tot));
    chk("accepted", 128'(acc), 128'(tot));
    chk("done_count", 128'(done_cnt), 128'(1));
    if (check_tput) chk("throughput", 128'(last_st - first_st), 128'(tot - 1));
    @(posedge clk); #1;
    z_valid_i = 1'b0; tcdm_gnt_i = 1'b0; start_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b1;
    base_address_i = 32'h100; y_columns_i = 16'd6; x_rows_i = 16'd2;
    z_valid_i = 1'b1; z_data_i = '1; tcdm_gnt_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 128'(z_ready_o), 128'(0));
    chk("rst_req", 128'(tcdm_req_o), 128'(0));
    chk("rst_add", 128'(tcdm_add_o), 128'(0));
    chk("rst_be", 128'(tcdm_be_o), 128'(0));
    chk("rst_data", tcdm_data_o, 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_done", 128'(done_o), 128'(0));
    @(posedge clk); #1;
    rst_ni = 1'b1; start_i = 1'b0; z_valid_i = 1'b0; tcdm_gnt_i = 1'b0;

    run_job(32'h100, 6, 2, 100, 100, 0, 1'b0, 1'b0);
    run_job(32'h100, 8, 3, 100, 100, 0, 1'b0, 1'b1);
    run_job(32'h100, 6, 2, 50, 70, 0, 1'b0, 1'b0);
    run_job(32'h100, 6, 2, 50, 100, 0, 1'b0, 1'b0);
    run_job(32'h100, 0, 5, 100, 100, 0, 1'b0, 1'b0);
    run_job(32'h100, 3, 0, 100, 100, 0, 1'b0, 1'b0);
    run_job(32'h100, 6, 2, 100, 100, 2, 1'b0, 1'b0);
    run_job(32'h100, 6, 2, 100, 100, 0, 1'b0, 1'b0);
    run_job(32'h100, 6, 2, 100, 100, 0, 1'b1, 1'b0);
    for (int j = 0; j < 6; j++) begin
      run_job(32'hFFFF_FF00 + 32'($urandom_range(63) * 4), int'($urandom_range(13, 1)),
              int'($urandom_range(4, 1)), 60, 60, 0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
